mont_enter: RTL
===============

# mont_enter

Bit-serial converter into the Montgomery domain: computes y = a·2^k mod p by MSB-style doubling with conditional subtraction, one bit per clock. It is the entry counterpart to the Montgomery multiplier (`y_calc`), which removes a 2^k factor; this block adds one. It sits in front of the modular-exponentiation datapath and feeds converted operands to `y_calc`, using the same operand width, size encoding and one-cycle done pulse.

## Interface
- NBITS, 2048, operand/modulus width in bits
- CNTW, $clog2(NBITS)+3, width of k_size and the iteration counter
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start_p  in  1  start pulse; a, p, k_size sampled on the edge where it is high and busy=0
- a  in  NBITS  operand, any value < 2^NBITS
- p  in  NBITS  modulus; odd, 2^(NBITS-1) < p < 2^NBITS
- k_size  in  CNTW  exponent k (number of doublings), 0 ≤ k < 2^CNTW
- y  out  NBITS  result a·2^k mod p; valid from done_irq_p until next accepted start
- busy  out  1  high while a conversion is in progress (LOAD, RUN, DONE)
- done_irq_p  out  1  single-cycle completion pulse

## Operation
- Reset state: FSM=IDLE, u=0, cnt=0, captured p=0; outputs y=0, busy=0, done_irq_p=0.
- FSM states IDLE, LOAD, RUN, DONE; busy = (state != IDLE); done_irq_p = (state == DONE), registered.
- IDLE: start_p=1 → capture a, p, k_size; go to LOAD. start_p=0 → stay; u and y unchanged.
- LOAD: u <= (a ≥ p) ? a − p : a (a < 2^NBITS < 2p, so one subtraction suffices); cnt <= k; next = RUN if k≠0, else DONE.
- RUN, per cycle: d = 2u (NBITS+1 bits); r = d − p computed NBITS+2 bits wide; u <= borrow(r) ? d : r[NBITS-1:0]; cnt <= cnt − 1; when cnt==1 next = DONE.
- Invariant: u < p after every LOAD/RUN update; y = u[NBITS-1:0].
- DONE: one cycle; done_irq_p=1; next = IDLE. u is held.
- start_p while busy=1 (including DONE) is ignored; no capture, no restart.
- Captured p and k are used for the whole run; input changes after capture have no effect.
- Operand a is needed only in LOAD and is not stored separately.
- p violating the range (even or ≤ 2^(NBITS-1)) gives undefined y, but the FSM still completes in k+2 cycles.

## Timing
- Edge E0 samples start_p=1. After E0: LOAD. After E1: RUN (k≥1) or DONE (k=0).
- RUN iterations occur on E2..E(k+1). After E(k+1): DONE, done_irq_p high for exactly one cycle. After E(k+2): IDLE, busy low.
- Latency from accepting edge to done_irq_p rising: k+1 edges. Total busy time: k+2 cycles.
- Back-to-back: the earliest next start is sampled on the first edge with busy=0, i.e. E(k+2) is too early and E(k+3) is accepted.
- y is stable from the DONE cycle until the LOAD update of the next conversion.
- rst_n assertion at any time, including mid-RUN, returns all state and outputs to reset values immediately; no done pulse is produced for the aborted run.
- Counter width CNTW means k up to 2^CNTW − 1 with no wrap; cnt never decrements below 1 in RUN.

## Test plan
- NBITS=8, p=0xB5, a=0x01, k=8 → y=0x4B, done_irq_p one cycle, 10 edges after start (high after E9), busy low after E10.
- NBITS=8, p=0xB5, a=0xFF, k=0 → LOAD reduction only: y=0x4A; done_irq_p high after E1.
- NBITS=8, p=0xB5, a=0xB5, k=3 → y=0x00. NBITS=8, p=0xB5, a=0x64, k=8 → y=0x4F.
- Start while busy: start_p pulsed mid-RUN and in DONE with different a → ignored, first result unchanged. Start at E(k+3) → accepted.
- Reset mid-RUN (k=8, assert rst_n low after E4) → y=0, busy=0, no done pulse. A new start after release produces the correct result.
- NBITS=2048, random odd p with MSB set, random a, k=2048: output fed through `y_calc` with operand 1 returns a mod p. Covers 1000 random vectors against a golden model.

Source files
------------

// File: rtl/mont_enter.sv
// Bit-serial conversion into the Montgomery domain: y = a * 2^k mod p,
// one modular doubling per clock after a single reducing load step.
module mont_enter #(
  parameter int NBITS = 2048,
  parameter int CNTW  = $clog2(NBITS) + 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_p,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] p,
  input  logic [CNTW-1:0]  k_size,
  output logic [NBITS-1:0] y,
  output logic             busy,
  output logic             done_irq_p
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [NBITS-1:0] u;
  logic [NBITS-1:0] p_q;
  logic [CNTW-1:0]  cnt;

  logic [NBITS:0]   load_diff;
  logic [NBITS:0]   dbl;
  logic [NBITS+1:0] run_diff;
  logic [NBITS-1:0] u_load;
  logic [NBITS-1:0] u_run;

  // Both steps are "subtract p unless that borrows"; the borrow is the MSB of
  // the widened difference. The raw operand sits in u between capture and LOAD.
  always_comb begin
    load_diff = {1'b0, u} - {1'b0, p_q};
    dbl       = {u, 1'b0};
    run_diff  = {1'b0, dbl} - {2'b00, p_q};
    u_load    = load_diff[NBITS] ? u : load_diff[NBITS-1:0];
    u_run     = run_diff[NBITS+1] ? dbl[NBITS-1:0] : run_diff[NBITS-1:0];
  end

  // Handshake: start_p is a request that is taken only on an edge where busy
  // is low; done_irq_p is a one-cycle completion strobe, y valid from then on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      u          <= '0;
      p_q        <= '0;
      cnt        <= '0;
      y          <= '0;
      busy       <= 1'b0;
      done_irq_p <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_irq_p <= 1'b0;
          if (start_p) begin
            u     <= a;
            p_q   <= p;
            cnt   <= k_size;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          u <= u_load;
          y <= u_load;
          if (cnt != '0) begin
            state <= RUN;
          end else begin
            state      <= DONE;
            done_irq_p <= 1'b1;
          end
        end
        RUN: begin
          u   <= u_run;
          y   <= u_run;
          cnt <= cnt - CNTW'(1);
          if (cnt == CNTW'(1)) begin
            state      <= DONE;
            done_irq_p <= 1'b1;
          end
        end
        DONE: begin
          done_irq_p <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          done_irq_p <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
